// File: rtl/apu_pkg.sv
// Shared APU constants and types for the mixer and its PDM back end.
package apu_pkg;

  localparam int APU_NUM_CHANNELS  = 4;
  localparam int APU_CH_WIDTH      = 9;
  localparam int APU_VOL_WIDTH     = 4;
  localparam int APU_OUT_WIDTH     = 16;
  // Sum of NUM_CHANNELS full-scale products; sized so the accumulator never wraps.
  localparam int APU_MIX_ACC_WIDTH = APU_CH_WIDTH + APU_VOL_WIDTH + $clog2(APU_NUM_CHANNELS);

  typedef enum logic [1:0] {
    MIX_IDLE,
    MIX_ACC,
    MIX_OUT
  } mix_state_e;

endpackage

// File: rtl/apu_pdm_modulator.sv
// First-order sigma-delta modulator: the density of ones on o_pdm tracks
// i_sample / 2^WIDTH. The carry out of the phase accumulator is the bit stream.
module apu_pdm_modulator
  import apu_pkg::*;
#(
  parameter int WIDTH = APU_OUT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sample,
  output logic             o_pdm
);

  logic [WIDTH-1:0] pdm_acc;
  logic [WIDTH:0]   pdm_sum;

  // Phase accumulator plus incoming sample, with the carry kept as the top bit.
  always_comb begin
    pdm_sum = {1'b0, pdm_acc} + {1'b0, i_sample};
  end

  // Advance the accumulator every clock and register the carry as the output bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pdm_acc <= '0;
      o_pdm   <= 1'b0;
    end else begin
      pdm_acc <= pdm_sum[WIDTH-1:0];
      o_pdm   <= pdm_sum[WIDTH];
    end
  end

endmodule

// File: rtl/apu_mixer.sv
// APU channel mixer: snapshots the channel samples on a strobe, multiplies each
// by its volume (or zero when muted) one channel per clock, then shifts and
// saturates the sum into an unsigned output sample with a one-cycle valid.
// The final sum is saturated as the last channel is accumulated, so the new
// sample and its valid pulse are visible during the OUT cycle, where a strobe
// is still rejected. Optional feature: define APU_MIXER_PDM_EN to add o_pdm
// and the sigma-delta modulator fed from o_sample.
module apu_mixer
  import apu_pkg::*;
#(
  parameter int NUM_CHANNELS = APU_NUM_CHANNELS,
  parameter int CH_WIDTH     = APU_CH_WIDTH,
  parameter int VOL_WIDTH    = APU_VOL_WIDTH,
  parameter int OUT_WIDTH    = APU_OUT_WIDTH
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_sample_stb,
  input  logic [NUM_CHANNELS*CH_WIDTH-1:0]  i_channels,
  input  logic [NUM_CHANNELS*VOL_WIDTH-1:0] i_volume,
  input  logic [NUM_CHANNELS-1:0]           i_mute,
  input  logic [1:0]                        i_master_shift,
  output logic [OUT_WIDTH-1:0]              o_sample,
  output logic                              o_sample_valid,
  output logic                              o_busy,
`ifdef APU_MIXER_PDM_EN
  output logic                              o_pdm,
`endif
  output logic                              o_overrun
);

  localparam int PROD_W = CH_WIDTH + VOL_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NUM_CHANNELS);
  localparam int SHF_W  = ACC_W + 3;
  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  mix_state_e                        state;
  logic [IDX_W-1:0]                  idx;
  logic [ACC_W-1:0]                  acc;
  logic [NUM_CHANNELS*CH_WIDTH-1:0]  ch_q;
  logic [NUM_CHANNELS*VOL_WIDTH-1:0] vol_q;
  logic [NUM_CHANNELS-1:0]           mute_q;
  logic [1:0]                        shift_q;

  logic [CH_WIDTH-1:0]  ch_sel;
  logic [VOL_WIDTH-1:0] vol_sel;
  logic [PROD_W-1:0]    product;
  logic [PROD_W-1:0]    term;
  logic [ACC_W-1:0]     acc_next;
  logic [SHF_W-1:0]     shifted;
  logic [OUT_WIDTH-1:0] sat_sample;

  // Serial MAC datapath for the channel selected by idx, plus shift and saturation
  // of the running sum (only consumed when idx is the last channel).
  always_comb begin
    // NOTE: every signal here is assigned on every pass, so no latch is inferred.
    ch_sel     = ch_q[idx*CH_WIDTH +: CH_WIDTH];
    vol_sel    = vol_q[idx*VOL_WIDTH +: VOL_WIDTH];
    product    = PROD_W'(ch_sel) * PROD_W'(vol_sel);
    term       = mute_q[idx] ? '0 : product;
    acc_next   = acc + ACC_W'(term);
    shifted    = SHF_W'(acc_next) << shift_q;
    sat_sample = (|shifted[SHF_W-1:OUT_WIDTH]) ? '1 : shifted[OUT_WIDTH-1:0];
  end

  // Mix sequencer: IDLE snapshots on strobe, ACC adds one channel per clock, OUT
  // is the cycle the new sample is presented; strobes outside IDLE flag overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the snapshot registers are plain flops, not a RAM, so they are reset
      // along with the rest of the state to keep a clean, deterministic start.
      state          <= MIX_IDLE;
      idx            <= '0;
      acc            <= '0;
      ch_q           <= '0;
      vol_q          <= '0;
      mute_q         <= '0;
      shift_q        <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_busy         <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      o_sample_valid <= 1'b0;
      if (i_sample_stb && (state != MIX_IDLE)) begin
        o_overrun <= 1'b1;
      end
      case (state)
        MIX_IDLE: begin
          if (i_sample_stb) begin
            ch_q    <= i_channels;
            vol_q   <= i_volume;
            mute_q  <= i_mute;
            shift_q <= i_master_shift;
            acc     <= '0;
            idx     <= '0;
            o_busy  <= 1'b1;
            state   <= MIX_ACC;
          end
        end
        MIX_ACC: begin
          acc <= acc_next;
          if (idx == LAST_IDX) begin
            o_sample       <= sat_sample;
            o_sample_valid <= 1'b1;
            o_busy         <= 1'b0;
            state          <= MIX_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        MIX_OUT: begin
          state <= MIX_IDLE;
        end
        default: begin
          state <= MIX_IDLE;
        end
      endcase
    end
  end

`ifdef APU_MIXER_PDM_EN
  apu_pdm_modulator #(
    .WIDTH (OUT_WIDTH)
  ) u_pdm (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_sample (o_sample),
    .o_pdm    (o_pdm)
  );
`endif

endmodule

// File: tb/tb_apu_mixer.sv
// Self-checking bench for apu_mixer: a cycle-level transaction model (accept
// time, completion time, expected value from plain arithmetic) is compared
// against the DUT on every falling edge, alongside hand-computed directed cases.
module tb_apu_mixer;
  import apu_pkg::*;

  localparam int NC = APU_NUM_CHANNELS;
  localparam int CW = APU_CH_WIDTH;
  localparam int VW = APU_VOL_WIDTH;
  localparam int OW = APU_OUT_WIDTH;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_sample_stb;
  logic [NC*CW-1:0]  i_channels;
  logic [NC*VW-1:0]  i_volume;
  logic [NC-1:0]     i_mute;
  logic [1:0]        i_master_shift;
  logic [OW-1:0]     o_sample;
  logic              o_sample_valid;
  logic              o_busy;
  logic              o_overrun;
`ifdef APU_MIXER_PDM_EN
  logic              o_pdm;
`endif

  apu_mixer dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_sample_stb   (i_sample_stb),
    .i_channels     (i_channels),
    .i_volume       (i_volume),
    .i_mute         (i_mute),
    .i_master_shift (i_master_shift),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .o_busy         (o_busy),
`ifdef APU_MIXER_PDM_EN
    .o_pdm          (o_pdm),
`endif
    .o_overrun      (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit compare_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state, expressed as "after rising edge number m_edge".
  int m_edge      = 0;
  bit m_pending   = 1'b0;
  int m_done_edge = 0;
  int m_free_edge = 0;
  int m_pend_val  = 0;
  int m_sample    = 0;
  bit m_busy      = 1'b0;
  bit m_valid     = 1'b0;
  bit m_overrun   = 1'b0;

  // Expected mix result straight from the arithmetic definition.
  function automatic int mix_value(input logic [NC*CW-1:0] ch, input logic [NC*VW-1:0] vol,
                                   input logic [NC-1:0] mute, input logic [1:0] shift);
    int sum = 0;
    int s;
    for (int i = 0; i < NC; i++) begin
      if (!mute[i]) sum += int'(ch[i*CW +: CW]) * int'(vol[i*VW +: VW]);
    end
    s = sum << shift;
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic model_reset();
    m_pending   = 1'b0;
    m_free_edge = 0;
    m_sample    = 0;
    m_busy      = 1'b0;
    m_valid     = 1'b0;
    m_overrun   = 1'b0;
  endtask

  // One rising edge: a strobe accepted at edge e completes at e+NC and the
  // mixer is free again from edge e+NC+2; any other strobe is an overrun.
  task automatic model_update(input bit stb, input logic [NC*CW-1:0] ch, input logic [NC*VW-1:0] vol,
                              input logic [NC-1:0] mute, input logic [1:0] shift);
    m_edge++;
    m_valid = 1'b0;
    if (m_pending && (m_edge == m_done_edge)) begin
      m_valid   = 1'b1;
      m_sample  = m_pend_val;
      m_pending = 1'b0;
    end
    m_busy = m_pending;
    if (stb) begin
      if (m_edge >= m_free_edge) begin
        m_pending   = 1'b1;
        m_done_edge = m_edge + NC;
        m_free_edge = m_edge + NC + 2;
        m_pend_val  = mix_value(ch, vol, mute, shift);
        m_busy      = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endtask

  // Compare process: DUT against the model on every falling edge.
  always @(negedge i_clk) begin
    if (compare_on) begin
      check("cmp_busy",    32'(o_busy),         32'(m_busy));
      check("cmp_valid",   32'(o_sample_valid), 32'(m_valid));
      check("cmp_sample",  32'(o_sample),       32'(m_sample));
      check("cmp_overrun", 32'(o_overrun),      32'(m_overrun));
    end
  end

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, and return 1 time unit later with outputs settled.
  task automatic tick(input bit stb, input logic [NC*CW-1:0] ch, input logic [NC*VW-1:0] vol,
                      input logic [NC-1:0] mute, input logic [1:0] shift);
    @(negedge i_clk);
    i_sample_stb   = stb;
    i_channels     = ch;
    i_volume       = vol;
    i_mute         = mute;
    i_master_shift = shift;
    @(posedge i_clk);
    model_update(stb, ch, vol, mute, shift);
    #1;
  endtask

  task automatic rand_tick(input bit stb);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    tick(stb, r[NC*CW-1:0], 16'($urandom()), 4'($urandom()), 2'($urandom()));
  endtask

  initial begin
    // Reset state.
    i_rst = 1'b1;
    i_sample_stb = 1'b0;
    i_channels = '0;
    i_volume = '0;
    i_mute = '0;
    i_master_shift = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_sample",  32'(o_sample),       32'd0);
    check("rst_valid",   32'(o_sample_valid), 32'd0);
    check("rst_busy",    32'(o_busy),         32'd0);
    check("rst_overrun", 32'(o_overrun),      32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    compare_on = 1'b1;

    // Single channel at full scale: 511*15 = 7665, busy for four cycles.
    tick(1'b1, {27'd0, 9'h1FF}, {12'd0, 4'd15}, 4'b0000, 2'd0);
    check("t2_busy_t1", 32'(o_busy), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      rand_tick(1'b0);
      check("t2_busy_mid", 32'(o_busy), 32'd1);
    end
    rand_tick(1'b0);
    check("t2_valid_t5", 32'(o_sample_valid), 32'd1);
    check("t2_sample",   32'(o_sample),       32'd7665);
    check("t2_busy_t5",  32'(o_busy),         32'd0);
    rand_tick(1'b0);
    check("t2_valid_drop", 32'(o_sample_valid), 32'd0);
    check("t2_hold",       32'(o_sample),       32'd7665);

    // All channels full scale: 30660<<3 saturates, 30660<<1 = 61320.
    tick(1'b1, {NC{9'h1FF}}, {NC{4'd15}}, 4'b0000, 2'd3);
    repeat (4) rand_tick(1'b0);
    check("t3_sat", 32'(o_sample), 32'hFFFF);
    rand_tick(1'b0);
    tick(1'b1, {NC{9'h1FF}}, {NC{4'd15}}, 4'b0000, 2'd1);
    repeat (4) rand_tick(1'b0);
    check("t3_shift1", 32'(o_sample), 32'd61320);
    rand_tick(1'b0);

    // Mute on channel 1, random inputs right after the strobe: 3*100*2 = 600.
    tick(1'b1, {NC{9'd100}}, {NC{4'd2}}, 4'b0010, 2'd0);
    repeat (4) rand_tick(1'b0);
    check("t4_mute", 32'(o_sample), 32'd600);
    rand_tick(1'b0);

    // Overrun: strobe at T+2 and T+5 rejected, T+6 accepted.
    check("t5_ovr_before", 32'(o_overrun), 32'd0);
    tick(1'b1, {NC{9'd10}}, {NC{4'd1}}, 4'b0000, 2'd0);
    rand_tick(1'b0);
    rand_tick(1'b1);
    check("t5_ovr_set", 32'(o_overrun), 32'd1);
    rand_tick(1'b0);
    rand_tick(1'b0);
    check("t5_first_valid", 32'(o_sample_valid), 32'd1);
    check("t5_first_val",   32'(o_sample),       32'd40);
    tick(1'b1, {NC{9'd7}}, {NC{4'd7}}, 4'b0000, 2'd0);
    check("t5_t5_reject", 32'(o_busy), 32'd0);
    tick(1'b1, {NC{9'd1}}, {NC{4'd1}}, 4'b0000, 2'd0);
    check("t5_t6_accept", 32'(o_busy), 32'd1);
    repeat (4) rand_tick(1'b0);
    check("t5_second_val", 32'(o_sample),  32'd4);
    check("t5_ovr_sticky", 32'(o_overrun), 32'd1);
    rand_tick(1'b0);

    // Reset in the middle of ACC: outputs clear at once, no valid afterwards.
    tick(1'b1, {NC{9'h1FF}}, {NC{4'd15}}, 4'b0000, 2'd0);
    rand_tick(1'b0);
    rand_tick(1'b0);
    #1;
    i_rst = 1'b1;
    model_reset();
    #1;
    check("t1_rst_busy",    32'(o_busy),         32'd0);
    check("t1_rst_sample",  32'(o_sample),       32'd0);
    check("t1_rst_valid",   32'(o_sample_valid), 32'd0);
    check("t1_rst_overrun", 32'(o_overrun),      32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rand_tick(1'b0);
      check("t1_no_valid", 32'(o_sample_valid), 32'd0);
    end
    check("t1_sample_zero", 32'(o_sample), 32'd0);

    // Randomized traffic, occasionally at full scale to exercise saturation.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        tick($urandom_range(0, 1) == 1, {NC{9'h1FF}}, {NC{4'd15}}, 4'($urandom()), 2'($urandom()));
      end else begin
        rand_tick($urandom_range(0, 2) == 0);
      end
    end
    repeat (8) rand_tick(1'b0);

`ifdef APU_MIXER_PDM_EN
    // PDM density: (2*256*8)<<3 = 0x8000 gives half ones; zero gives no ones.
    begin
      int ones;
      tick(1'b1, {18'd0, 9'd256, 9'd256}, {8'd0, 4'd8, 4'd8}, 4'b0000, 2'd3);
      repeat (6) rand_tick(1'b0);
      check("pdm_sample", 32'(o_sample), 32'h8000);
      ones = 0;
      for (int k = 0; k < 256; k++) begin
        rand_tick(1'b0);
        ones += int'(o_pdm);
      end
      check("pdm_density", 32'((ones >= 127) && (ones <= 129)), 32'd1);
      tick(1'b1, {NC{9'h1FF}}, {NC{4'd15}}, 4'b1111, 2'd0);
      repeat (6) rand_tick(1'b0);
      ones = 0;
      for (int k = 0; k < 64; k++) begin
        rand_tick(1'b0);
        ones += int'(o_pdm);
      end
      check("pdm_zero", 32'(ones), 32'd0);
    end
`endif

    compare_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
